// File: rtl/control_unit_if.sv
// control_unit_if
// Groups the control unit's datapath-facing signals into one bundle.
//   master : held by control_unit; reads IR, CON_FF and Stop, drives every
//            bus enable, register load, memory strobe, ALU opcode and Run.
//   slave  : held by the DataPath side (or a bench); drives IR, CON_FF and
//            Stop and observes the strobes.
// Clock and clear stay plain ports on the module that uses this bundle.
interface control_unit_if;
    logic [31:0] IR;
    logic        CON_FF;
    logic        Stop;

    logic        PCout, Zlowout, MDRout, Rout, BAout, Cout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin;
    logic        Gra, Grb, Grc;
    logic        IncPC;
    logic        Read, Write;
    logic [4:0]  operation;
    logic        Run;

    modport master (
        input  IR, CON_FF, Stop,
        output PCout, Zlowout, MDRout, Rout, BAout, Cout,
        output PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin,
        output Gra, Grb, Grc, IncPC, Read, Write, operation, Run
    );

    modport slave (
        output IR, CON_FF, Stop,
        input  PCout, Zlowout, MDRout, Rout, BAout, Cout,
        input  PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin,
        input  Gra, Grb, Grc, IncPC, Read, Write, operation, Run
    );
endinterface

// File: rtl/control_unit.sv
// control_unit
// Hardwired Moore control unit for DataPath. Steps each instruction through
// T0..T7 (fetch in T0..T2, execute from T3) and owns the Run/halt status.
// Ports:
//   Clock : rising-edge clock
//   clear : asynchronous active-low reset, forces RESET with all outputs 0
//   bus   : control_unit_if.master
//           inputs  IR (opcode IR[31:27]), CON_FF (branch flag), Stop
//           outputs bus enables, register loads, Gra/Grb/Grc, IncPC,
//                   Read/Write, operation[4:0], Run
module control_unit #(
    parameter logic [4:0] OP_ADD = 5'b00011,
    parameter logic [4:0] OP_AND = 5'b01001,
    parameter logic [4:0] OP_OR  = 5'b01010
) (
    input  logic           Clock,
    input  logic           clear,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    state_t     state, next_state;
    logic [4:0] opcode;
    logic       is_ld, is_ldi, is_st, is_alu, is_imm, is_br, is_jr, is_halt;
    logic       has_execute;
    logic       final_state;
    logic [4:0] imm_op;

    assign opcode  = bus.IR[31:27];
    assign is_ld   = (opcode == 5'b00000);
    assign is_ldi  = (opcode == 5'b00001);
    assign is_st   = (opcode == 5'b00010);
    assign is_alu  = (opcode >= 5'b00011) && (opcode <= 5'b01010);
    assign is_imm  = (opcode >= 5'b01011) && (opcode <= 5'b01101);
    assign is_br   = (opcode == 5'b10010);
    assign is_jr   = (opcode == 5'b10011);
    assign is_halt = (opcode == 5'b11010);

    // Opcodes that run past fetch; everything else (nop, unknown) ends at T2.
    assign has_execute = is_ld | is_ldi | is_st | is_alu | is_imm | is_br | is_jr;

    // addi/andi/ori share one datapath sequence and differ only in ALU code.
    assign imm_op = (opcode == 5'b01100) ? OP_AND :
                    (opcode == 5'b01101) ? OP_OR  : OP_ADD;

    // State register; clear drops the FSM to RESET without waiting for a clock.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) state <= RESET;
        else        state <= next_state;
    end

    // Next-state logic. final_state marks the last state of an instruction;
    // only there is Stop consulted, so a Stop pulse elsewhere has no effect.
    always_comb begin
        next_state  = state;
        final_state = 1'b0;
        case (state)
            RESET: next_state = T0;
            T0:    next_state = T1;
            T1:    next_state = T2;
            T2: begin
                if (is_halt)          next_state = HALT;
                else if (has_execute) next_state = T3;
                else                  final_state = 1'b1;
            end
            T3: begin
                if (is_jr) final_state = 1'b1;
                else       next_state  = T4;
            end
            T4:    next_state = T5;
            T5: begin
                if (is_ldi | is_alu | is_imm) final_state = 1'b1;
                else                          next_state  = T6;
            end
            T6: begin
                if (is_br) final_state = 1'b1;
                else       next_state  = T7;
            end
            T7:    final_state = 1'b1;
            HALT:  next_state = HALT;
            default: next_state = RESET;
        endcase
        if (final_state) next_state = bus.Stop ? HALT : T0;
    end

    // Moore outputs decoded from the state and the held IR. CON_FF only
    // matters in T6 of br, where it gates the PC update.
    always_comb begin
        bus.PCout     = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.MDRout    = 1'b0;
        bus.Rout      = 1'b0;
        bus.BAout     = 1'b0;
        bus.Cout      = 1'b0;
        bus.PCin      = 1'b0;
        bus.IRin      = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.Rin       = 1'b0;
        bus.CONin     = 1'b0;
        bus.Gra       = 1'b0;
        bus.Grb       = 1'b0;
        bus.Grc       = 1'b0;
        bus.IncPC     = 1'b0;
        bus.Read      = 1'b0;
        bus.Write     = 1'b0;
        bus.operation = 5'b00000;
        bus.Run       = (state != RESET) && (state != HALT);
        case (state)
            T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
            end
            T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            T3: begin
                if (is_ld | is_ldi | is_st) begin
                    bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                end else if (is_alu | is_imm) begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                end else if (is_br) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
                end else if (is_jr) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
                end
            end
            T4: begin
                if (is_ld | is_ldi | is_st) begin
                    bus.Cout = 1'b1; bus.Zin = 1'b1; bus.operation = OP_ADD;
                end else if (is_alu) begin
                    bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.operation = opcode;
                end else if (is_imm) begin
                    bus.Cout = 1'b1; bus.Zin = 1'b1; bus.operation = imm_op;
                end else if (is_br) begin
                    bus.PCout = 1'b1; bus.Yin = 1'b1;
                end
            end
            T5: begin
                if (is_ld | is_st) begin
                    bus.Zlowout = 1'b1; bus.MARin = 1'b1;
                end else if (is_ldi | is_alu | is_imm) begin
                    bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else if (is_br) begin
                    bus.Cout = 1'b1; bus.Zin = 1'b1; bus.operation = OP_ADD;
                end
            end
            T6: begin
                if (is_ld) begin
                    bus.Read = 1'b1; bus.MDRin = 1'b1;
                end else if (is_st) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                end else if (is_br && bus.CON_FF) begin
                    bus.Zlowout = 1'b1; bus.PCin = 1'b1;
                end
            end
            T7: begin
                if (is_ld) begin
                    bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else if (is_st) begin
                    bus.Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
